// File: rtl/tmds_pkg.sv
// Shared constants, branch-select enum and small helpers for the DVI/TMDS encoder.
// Optional output register stage is enabled by defining TMDS_REG_OUT_EN.
package tmds_pkg;

    localparam int SYM_W = 10;
    localparam int CNT_W = 6;

    localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ENC_CTRL,
        ENC_BALANCED,
        ENC_INVERT,
        ENC_KEEP
    } enc_sel_e;

    function automatic logic [3:0] countOnes8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [SYM_W-1:0] controlToken(input logic c1, input logic c0);
        logic [SYM_W-1:0] tok;
        case ({c1, c0})
            2'b00:   tok = CTRL_TOKEN_00;
            2'b01:   tok = CTRL_TOKEN_01;
            2'b10:   tok = CTRL_TOKEN_10;
            default: tok = CTRL_TOKEN_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS channel: stage 1 builds the transition-minimised qm word, stage 2 applies DC balancing.
// With TMDS_REG_OUT_EN defined an extra output register adds one cycle of latency.
module tmds_channel
    import tmds_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data_i,
    input  logic             c1_i,
    input  logic             c0_i,
    input  logic             de_i,
    output logic [SYM_W-1:0] sym_o
);

    localparam logic signed [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic signed [CNT_W-1:0] CNT_TWO  = 6'sd2;

    logic [3:0]              dataOnes;
    logic                    useXnor;
    logic [8:0]              qm_d, qm_q;
    logic [3:0]              n1_d, n1_q, n0_d, n0_q;
    logic                    de_q, c1_q, c0_q;
    logic signed [CNT_W-1:0] cnt_d, cnt_q;
    logic signed [CNT_W-1:0] n1s, n0s;
    logic                    cntPos, cntNeg;
    logic [SYM_W-1:0]        sym_d, sym_q;
    enc_sel_e                encSel;

    // Stage 1: XNOR chain when the byte is ones-heavy so the result has fewer transitions.
    always_comb begin
        dataOnes = countOnes8(data_i);
        useXnor  = (dataOnes > 4'd4) || ((dataOnes == 4'd4) && !data_i[0]);
        qm_d     = '0;
        qm_d[0]  = data_i[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = useXnor ? ~(qm_d[i-1] ^ data_i[i]) : (qm_d[i-1] ^ data_i[i]);
        end
        qm_d[8] = ~useXnor;
        n1_d    = countOnes8(qm_d[7:0]);
        n0_d    = 4'd8 - n1_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qm_q <= '0;
            n1_q <= '0;
            n0_q <= '0;
            de_q <= 1'b0;
            c1_q <= 1'b0;
            c0_q <= 1'b0;
        end else begin
            qm_q <= qm_d;
            n1_q <= n1_d;
            n0_q <= n0_d;
            de_q <= de_i;
            c1_q <= c1_i;
            c0_q <= c0_i;
        end
    end

    // Stage 2: pick invert/keep so the running disparity is pulled back towards zero.
    always_comb begin
        n1s    = {2'b00, n1_q};
        n0s    = {2'b00, n0_q};
        cntNeg = cnt_q[CNT_W-1];
        cntPos = !cnt_q[CNT_W-1] && (cnt_q != CNT_ZERO);

        encSel = ENC_KEEP;
        if (!de_q) begin
            encSel = ENC_CTRL;
        end else if ((cnt_q == CNT_ZERO) || (n1_q == n0_q)) begin
            encSel = ENC_BALANCED;
        end else if ((cntPos && (n1_q > n0_q)) || (cntNeg && (n0_q > n1_q))) begin
            encSel = ENC_INVERT;
        end

        sym_d = CTRL_TOKEN_00;
        cnt_d = CNT_ZERO;
        unique case (encSel)
            ENC_CTRL: begin
                sym_d = controlToken(c1_q, c0_q);
                cnt_d = CNT_ZERO;
            end
            ENC_BALANCED: begin
                sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                cnt_d = qm_q[8] ? (cnt_q + n1s - n0s) : (cnt_q + n0s - n1s);
            end
            ENC_INVERT: begin
                sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                cnt_d = cnt_q + (qm_q[8] ? CNT_TWO : CNT_ZERO) + n0s - n1s;
            end
            ENC_KEEP: begin
                sym_d = {1'b0, qm_q[8], qm_q[7:0]};
                cnt_d = cnt_q + n1s - n0s - (qm_q[8] ? CNT_ZERO : CNT_TWO);
            end
            default: begin
                sym_d = CTRL_TOKEN_00;
                cnt_d = CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_q <= CTRL_TOKEN_00;
            cnt_q <= CNT_ZERO;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef TMDS_REG_OUT_EN
    logic [SYM_W-1:0] out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= CTRL_TOKEN_00;
        end else begin
            out_q <= sym_q;
        end
    end

    assign sym_o = out_q;
`else
    assign sym_o = sym_q;
`endif

endmodule

// File: rtl/tmds_encoder.sv
// DVI/TMDS encoder: three aligned channel encoders, blue carries hsync/vsync during blanking.
// Define TMDS_REG_OUT_EN to add a third pipeline stage on the symbol outputs.
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       vga_r,
    input  logic [7:0]       vga_g,
    input  logic [7:0]       vga_b,
    input  logic             vga_hs,
    input  logic             vga_vs,
    input  logic             vga_de,
    output logic [SYM_W-1:0] tmds_r,
    output logic [SYM_W-1:0] tmds_g,
    output logic [SYM_W-1:0] tmds_b
);

    tmds_channel uBlue (
        .clk    (clk),
        .rst_n  (reset),
        .data_i (vga_b),
        .c1_i   (vga_vs),
        .c0_i   (vga_hs),
        .de_i   (vga_de),
        .sym_o  (tmds_b)
    );

    tmds_channel uGreen (
        .clk    (clk),
        .rst_n  (reset),
        .data_i (vga_g),
        .c1_i   (1'b0),
        .c0_i   (1'b0),
        .de_i   (vga_de),
        .sym_o  (tmds_g)
    );

    tmds_channel uRed (
        .clk    (clk),
        .rst_n  (reset),
        .data_i (vga_r),
        .c1_i   (1'b0),
        .c0_i   (1'b0),
        .de_i   (vga_de),
        .sym_o  (tmds_r)
    );

endmodule

// File: doc/tmds_encoder.md
# tmds_encoder

DVI/TMDS encoder sitting directly downstream of the VGA timing/pixel generator: consumes its 24-bit RGB, sync and display-enable outputs and produces three 10-bit TMDS symbols per pixel clock for the HDMI/DVI serializer. It applies the DVI 1.0 transition-minimised, DC-balanced encoding during active video and emits control tokens during blanking. It is fully pipelined: one pixel in and one symbol triple out every cycle, with no stalls.

## Interface
- No parameters.
- clk  input  1  pixel clock; all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- vga_r  input  8  red pixel data; valid when vga_de=1
- vga_g  input  8  green pixel data
- vga_b  input  8  blue pixel data
- vga_hs  input  1  hsync level, encoded as-is (no polarity change)
- vga_vs  input  1  vsync level, encoded as-is
- vga_de  input  1  1 = active video, 0 = blanking
- tmds_r  output  10  red channel symbol, bit 0 transmitted first
- tmds_g  output  10  green channel symbol
- tmds_b  output  10  blue channel symbol

## Operation
- Three identical channel encoders; blue gets control {c1,c0}={vga_vs,vga_hs}, green and red get {0,0}.
- Stage 1, per channel: N1 = ones in D. If N1>4 or (N1==4 and D[0]==0): XNOR chain, qm[8]=0; else XOR chain, qm[8]=1. qm[0]=D[0]. Register qm[8:0], N1/N0 of qm[7:0], de, c1, c0.
- Stage 2, per channel, running disparity cnt (6-bit signed, two's complement):
  - de=0: output control token (00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011, written bit9..bit0); cnt←0.
  - de=1 and (cnt==0 or N1==N0): q[9]=~qm[8], q[8]=qm[8], q[7:0]=qm[8]?qm:~qm; cnt += qm[8] ? (N1−N0) : (N0−N1).
  - de=1 and ((cnt>0 and N1>N0) or (cnt<0 and N0>N1)): q={1,qm[8],~qm[7:0]}; cnt += 2·qm[8] + (N0−N1).
  - else: q={0,qm[8],qm[7:0]}; cnt += (N1−N0) − 2·(~qm[8]).
- cnt stays within ±10 by construction; no saturation logic.
- Reset (any time, including mid-line): all symbol outputs ← 1101010100, cnt ← 0, pipeline de ← 0. First encoding after reset release starts with cnt=0.

## Timing
- Latency 2 cycles from inputs to tmds_*; throughput 1 pixel/cycle.
- All three channels aligned: a given pixel's symbols appear on the same cycle.
- de 1→0 and 0→1 transitions take effect on the exact pixel they accompany; cnt reset applies on every blanking cycle.
- Outputs are registered; no combinational path input→output.

## Configuration
- TMDS_REG_OUT_EN defined: an extra output register stage after stage 2; latency 3 cycles; reset value of the extra stage also 1101010100.
- Undefined: latency 2 cycles, stage-2 registers drive outputs directly.

## Structure
- Shared package: four control-token constants, cnt width (6), symbol width (10).
- One sub-module tmds_channel (8-bit data, c1, c0, de in; 10-bit symbol out), instantiated three times by tmds_encoder.

## Test plan
- Reset held low with random inputs → all outputs 1101010100; release, de=0, hs=1, vs=0 → tmds_b=0010101011, tmds_g=tmds_r=1101010100 after 2 cycles.
- de=1, blue=0x00 for 3 pixels from cnt=0 → tmds_b 0100000000, 1111111111, 0100000000; cnt −8, +2, −6.
- de=1, blue=0xFF from cnt=0 → tmds_b=1000000000 at cycle 2.
- Random data, 10000 active pixels → every symbol decodes (reference decoder) to input; cumulative disparity stays within ±10 at every cycle.
- Blanking cycle between two active runs → cnt observed 0 at first active pixel; first symbol matches cnt==0 branch.
- Assert reset low mid-line for 1 cycle → outputs 1101010100 asynchronously, encoding restarts with cnt=0; with TMDS_REG_OUT_EN latency measured as 3.
